// File: rtl/uart_rx_line_assembler.sv
// uart_rx_line_assembler
//   Assembles terminated text lines from a UART byte stream into a small line
//   buffer. A complete line is held until the consumer acks it. Overlong lines
//   are discarded up to their terminator. A partial line is abandoned when the
//   gap between bytes grows too long. Bytes that arrive while a line is held
//   are dropped and counted.
// Ports
//   uart_clk, uart_rst_n   clock, synchronous active-low reset
//   rx_data, rx_done       byte and its one-cycle strobe from the UART receiver
//   line_valid, line_len   a complete line is held, and its byte count
//   rd_addr, rd_data       buffer read port, one cycle of latency
//   line_ack               consumer releases the held line
//   overflow_err           pulse: line longer than the buffer
//   timeout_err            pulse: partial line abandoned after an idle gap
//   drop_cnt               saturating count of bytes dropped while holding
module uart_rx_line_assembler #(
  parameter int          ADDR_W      = 4,
  parameter logic [7:0]  TERM_CHAR   = 8'h0A,
  parameter bit          STRIP_CR    = 1'b1,
  parameter int unsigned TIMEOUT_CYC = 50_000_000
) (
  input  logic              uart_clk,
  input  logic              uart_rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_done,
  output logic              line_valid,
  output logic [ADDR_W:0]   line_len,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  input  logic              line_ack,
  output logic              overflow_err,
  output logic              timeout_err,
  output logic [7:0]        drop_cnt
);
  localparam int          MAX_LEN  = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] MAX_PTR = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [31:0] IDLE_LIM = TIMEOUT_CYC - 1;

  typedef enum logic [1:0] {IDLE, COLLECT, HOLD, DISCARD} state_t;
  state_t state, state_nxt;

  logic [7:0]        line_mem [MAX_LEN];
  logic [ADDR_W:0]   wr_ptr;
  logic [31:0]       idle_cnt;

  logic byte_ev, is_term, full, timeout_hit;
  logic mem_we, latch_line, ovf, tmo, drop, release_line, counting;
  logic [ADDR_W-1:0] wr_addr;

  // A stripped CR is not a byte at all: the idle counter keeps running.
  assign byte_ev     = rx_done && !(STRIP_CR && rx_data == 8'h0D);
  assign is_term     = rx_data == TERM_CHAR;
  assign full        = wr_ptr == MAX_PTR;
  assign timeout_hit = idle_cnt == IDLE_LIM;

  // state register
  always_ff @(posedge uart_clk) begin
    if (!uart_rst_n) state <= IDLE;
    else             state <= state_nxt;
  end

  // next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (byte_ev && !is_term) state_nxt = COLLECT;
      COLLECT: if (byte_ev) begin
                 if (is_term)   state_nxt = HOLD;
                 else if (full) state_nxt = DISCARD;
               end else if (timeout_hit) state_nxt = IDLE;
      HOLD:    if (line_ack) state_nxt = IDLE;
      DISCARD: if (byte_ev) begin
                 if (is_term) state_nxt = IDLE;
               end else if (timeout_hit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // per-state controls for the datapath
  always_comb begin
    counting     = (state == COLLECT) || (state == DISCARD);
    mem_we       = byte_ev && !is_term &&
                   ((state == IDLE) || ((state == COLLECT) && !full));
    wr_addr      = (state == IDLE) ? '0 : wr_ptr[ADDR_W-1:0];
    latch_line   = (state == COLLECT) && byte_ev && is_term;
    ovf          = (state == COLLECT) && byte_ev && !is_term && full;
    tmo          = counting && !byte_ev && timeout_hit;
    drop         = (state == HOLD) && byte_ev;
    release_line = (state == HOLD) && line_ack;
  end

  always_ff @(posedge uart_clk) begin
    if (!uart_rst_n) begin
      wr_ptr       <= '0;
      idle_cnt     <= '0;
      line_valid   <= 1'b0;
      line_len     <= '0;
      rd_data      <= '0;
      overflow_err <= 1'b0;
      timeout_err  <= 1'b0;
      drop_cnt     <= '0;
    end else begin
      overflow_err <= ovf;
      timeout_err  <= tmo;
      rd_data      <= line_mem[rd_addr];

      if (mem_we)
        wr_ptr <= (state == IDLE) ? {{ADDR_W{1'b0}}, 1'b1} : wr_ptr + 1'b1;
      else if (ovf || tmo || release_line)
        wr_ptr <= '0;

      // Counter parks at the limit for the cycle the timeout fires.
      if (byte_ev && ((state == IDLE) || counting))
        idle_cnt <= '0;
      else if (counting && !timeout_hit)
        idle_cnt <= idle_cnt + 32'd1;

      if (latch_line) begin
        line_len   <= wr_ptr;
        line_valid <= 1'b1;
      end else if (release_line) begin
        line_valid <= 1'b0;
      end

      if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

  // Buffer RAM is never cleared.
  always_ff @(posedge uart_clk) begin
    if (uart_rst_n && mem_we) line_mem[wr_addr] <= rx_data;
  end
endmodule

// File: tb/tb_uart_rx_line_assembler.sv
module tb_uart_rx_line_assembler;
  localparam int AW = 4;
  localparam int ML = 16;
  localparam int TC = 1000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_done = 1'b0;
  logic          line_valid;
  logic [AW:0]   line_len;
  logic [AW-1:0] rd_addr = '0;
  logic [7:0]    rd_data;
  logic          line_ack = 1'b0;
  logic          overflow_err, timeout_err;
  logic [7:0]    drop_cnt;

  uart_rx_line_assembler #(.ADDR_W(AW), .TERM_CHAR(8'h0A), .STRIP_CR(1'b1),
                           .TIMEOUT_CYC(TC)) dut (
    .uart_clk(clk), .uart_rst_n(rst_n), .rx_data(rx_data), .rx_done(rx_done),
    .line_valid(line_valid), .line_len(line_len), .rd_addr(rd_addr),
    .rd_data(rd_data), .line_ack(line_ack), .overflow_err(overflow_err),
    .timeout_err(timeout_err), .drop_cnt(drop_cnt));

  always #10 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  int trace_bad = 0, ov_cnt = 0, to_cnt = 0;

  // Reference model: the line under construction as a queue plus flags.
  logic [7:0] mq[$];
  bit m_hold, m_disc, e_ov, e_to;
  int m_idle, m_drop, m_len;

  function automatic void model_reset();
    mq.delete(); m_hold = 0; m_disc = 0; m_idle = 0; m_drop = 0; m_len = 0;
    e_ov = 0; e_to = 0;
  endfunction

  function automatic void model_cycle(bit done_in, logic [7:0] b, bit ack);
    bit d;
    d = done_in && (b != 8'h0D);
    e_ov = 0; e_to = 0;
    if (m_hold) begin
      if (d && m_drop < 255) m_drop++;
      if (ack) begin m_hold = 0; mq.delete(); end
    end else if (m_disc) begin
      if (d) begin
        if (b == 8'h0A) m_disc = 0; else m_idle = 0;
      end else if (m_idle == TC - 1) begin e_to = 1; m_disc = 0; end
      else m_idle++;
    end else if (mq.size() > 0) begin
      if (d) begin
        if (b == 8'h0A) begin m_hold = 1; m_len = mq.size(); end
        else if (mq.size() == ML) begin e_ov = 1; m_disc = 1; mq.delete(); m_idle = 0; end
        else begin mq.push_back(b); m_idle = 0; end
      end else if (m_idle == TC - 1) begin e_to = 1; mq.delete(); end
      else m_idle++;
    end else if (d && b != 8'h0A) begin
      mq.push_back(b); m_idle = 0;
    end
  endfunction

  // One clock: drive, let the edge happen, advance the model, track agreement.
  task automatic step(bit d, logic [7:0] b, bit ack);
    rx_done = d; rx_data = d ? b : 8'($urandom); line_ack = ack;
    @(posedge clk); #1;
    rx_done = 1'b0; line_ack = 1'b0;
    model_cycle(d, b, ack);
    ov_cnt += int'(overflow_err);
    to_cnt += int'(timeout_err);
    if (line_valid !== m_hold || overflow_err !== e_ov || timeout_err !== e_to ||
        drop_cnt !== 8'(m_drop) || (m_hold && line_len !== (AW+1)'(m_len)))
      trace_bad++;
  endtask

  task automatic send_str(string s, int gap);
    for (int i = 0; i < s.len(); i++) begin
      step(1'b1, s[i], 1'b0);
      repeat (gap) step(1'b0, 8'h00, 1'b0);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rx_done = 1'b1; rx_data = 8'h41;
    @(posedge clk); #1;
    rx_done = 1'b0;
    n_cmp++;
    if (line_valid !== 1'b0 || line_len !== '0 || rd_data !== 8'h00 ||
        overflow_err !== 1'b0 || timeout_err !== 1'b0 || drop_cnt !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_state got lv=%b len=%0d rd=%h ov=%b to=%b drop=%0d want all 0",
               line_valid, line_len, rd_data, overflow_err, timeout_err, drop_cnt);
    end
    rst_n = 1'b1; model_reset();
  endtask

  task automatic test_hello();
    string s = "Hello World!";
    int t0 = trace_bad;
    send_str("Hello World!\n", 433);
    n_cmp++;
    if (line_valid !== 1'b1 || line_len !== 5'd12) begin
      n_bad++; $display("FAIL hello_line got lv=%b len=%0d want lv=1 len=12", line_valid, line_len);
    end
    for (int i = 0; i < 12; i++) begin
      rd_addr = AW'(i);
      step(1'b0, 8'h00, 1'b0);
      n_cmp++;
      if (rd_data !== 8'(s[i])) begin
        n_bad++; $display("FAIL hello_rd[%0d] got %h want %h", i, rd_data, 8'(s[i]));
      end
    end
    step(1'b0, 8'h00, 1'b1);
    n_cmp++;
    if (line_valid !== 1'b0 || trace_bad != t0) begin
      n_bad++; $display("FAIL hello_ack got lv=%b trace_err=%0d want lv=0 trace_err=0",
                        line_valid, trace_bad - t0);
    end
  endtask

  task automatic test_cr_ack();
    send_str("AB\r\n", 3);
    n_cmp++;
    if (line_valid !== 1'b1 || line_len !== 5'd2) begin
      n_bad++; $display("FAIL cr_line got lv=%b len=%0d want lv=1 len=2", line_valid, line_len);
    end
    rd_addr = 0; step(1'b0, 8'h00, 1'b0);
    n_cmp++;
    if (rd_data !== 8'h41) begin n_bad++; $display("FAIL cr_rd0 got %h want 41", rd_data); end
    rd_addr = 1; step(1'b0, 8'h00, 1'b0);
    n_cmp++;
    if (rd_data !== 8'h42) begin n_bad++; $display("FAIL cr_rd1 got %h want 42", rd_data); end
    step(1'b0, 8'h00, 1'b1);
    n_cmp++;
    if (line_valid !== 1'b0) begin n_bad++; $display("FAIL cr_ack got lv=%b want 0", line_valid); end
  endtask

  task automatic test_overflow();
    int o0 = ov_cnt, t0 = trace_bad;
    for (int i = 0; i < 17; i++) step(1'b1, 8'($urandom_range(8'h20, 8'h7E)), 1'b0);
    step(1'b1, 8'h0A, 1'b0);
    n_cmp++;
    if (ov_cnt - o0 != 1 || line_valid !== 1'b0 || trace_bad != t0) begin
      n_bad++; $display("FAIL overflow got pulses=%0d lv=%b trace_err=%0d want 1 0 0",
                        ov_cnt - o0, line_valid, trace_bad - t0);
    end
    send_str("X\n", 1);
    rd_addr = 0; step(1'b0, 8'h00, 1'b0);
    n_cmp++;
    if (line_valid !== 1'b1 || line_len !== 5'd1 || rd_data !== 8'h58) begin
      n_bad++; $display("FAIL after_ovf got lv=%b len=%0d rd=%h want 1 1 58",
                        line_valid, line_len, rd_data);
    end
    step(1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_drop();
    string s = "hold";
    send_str("ok\n", 0);
    step(1'b1, 8'h33, 1'b1);
    n_cmp++;
    if (drop_cnt !== 8'd1 || line_valid !== 1'b0) begin
      n_bad++; $display("FAIL ack_with_byte got drop=%0d lv=%b want 1 0", drop_cnt, line_valid);
    end
    send_str("hold\n", 0);
    for (int i = 0; i < 300; i++) begin
      logic [7:0] b;
      b = 8'($urandom);
      if (b == 8'h0D) b = 8'h0A;
      step(1'b1, b, 1'b0);
    end
    n_cmp++;
    if (drop_cnt !== 8'd255 || line_valid !== 1'b1 || line_len !== 5'd4) begin
      n_bad++; $display("FAIL drop_sat got drop=%0d lv=%b len=%0d want 255 1 4",
                        drop_cnt, line_valid, line_len);
    end
    for (int i = 0; i < 4; i++) begin
      rd_addr = AW'(i); step(1'b0, 8'h00, 1'b0);
      n_cmp++;
      if (rd_data !== 8'(s[i])) begin
        n_bad++; $display("FAIL drop_hold_rd[%0d] got %h want %h", i, rd_data, 8'(s[i]));
      end
    end
    step(1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_timeout();
    int t0 = to_cnt;
    send_str("ab", 0);
    repeat (TC - 1) step(1'b0, 8'h00, 1'b0);
    n_cmp++;
    if (timeout_err !== 1'b0 || to_cnt != t0) begin
      n_bad++; $display("FAIL timeout_early got to=%b pulses=%0d want 0 0", timeout_err, to_cnt - t0);
    end
    step(1'b0, 8'h00, 1'b0);
    n_cmp++;
    if (timeout_err !== 1'b1 || line_valid !== 1'b0) begin
      n_bad++; $display("FAIL timeout_fire got to=%b lv=%b want 1 0", timeout_err, line_valid);
    end
    send_str("\n", 4);
    n_cmp++;
    if (line_valid !== 1'b0 || to_cnt - t0 != 1) begin
      n_bad++; $display("FAIL timeout_empty got lv=%b pulses=%0d want 0 1", line_valid, to_cnt - t0);
    end
  endtask

  task automatic test_reset_midline();
    send_str("Hel", 2);
    test_reset();
    send_str("Hi\n", 2);
    n_cmp++;
    if (line_valid !== 1'b1 || line_len !== 5'd2) begin
      n_bad++; $display("FAIL post_reset got lv=%b len=%0d want 1 2", line_valid, line_len);
    end
    step(1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_random();
    int t0 = trace_bad;
    for (int n = 0; n < 25; n++) begin
      int len = $urandom_range(1, 20);
      for (int i = 0; i < len; i++) begin
        int r = $urandom_range(0, 15);
        logic [7:0] c;
        c = (r == 0) ? 8'h0D : (r == 1) ? 8'h0A : 8'(8'h61 + $urandom_range(0, 25));
        step(1'b1, c, 1'b0);
        repeat ($urandom_range(0, 4)) step(1'b0, 8'h00, 1'b0);
        if ($urandom_range(0, 60) == 0) repeat (TC + 2) step(1'b0, 8'h00, 1'b0);
      end
      step(1'b1, 8'h0A, 1'b0);
      n_cmp++;
      if (line_valid !== m_hold) begin
        n_bad++; $display("FAIL rand_lv[%0d] got %b want %b", n, line_valid, m_hold);
      end
      if (m_hold) begin
        for (int i = 0; i < mq.size(); i++) begin
          rd_addr = AW'(i); step(1'b0, 8'h00, 1'b0);
          n_cmp++;
          if (rd_data !== mq[i]) begin
            n_bad++; $display("FAIL rand_rd[%0d][%0d] got %h want %h", n, i, rd_data, mq[i]);
          end
        end
        step(1'($urandom_range(0, 1)), 8'($urandom), 1'b1);
      end
    end
    n_cmp++;
    if (trace_bad != t0) begin
      n_bad++; $display("FAIL rand_trace got %0d cycle errors want 0", trace_bad - t0);
    end
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_hello();
    test_cr_ack();
    test_overflow();
    test_drop();
    test_timeout();
    test_reset_midline();
    test_random();
    n_cmp++;
    if (trace_bad != 0) begin
      n_bad++; $display("FAIL cycle_trace got %0d cycle errors want 0", trace_bad);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
